// File: rtl/register_bank_reader.sv
// Register bank with a plain write port and a handshaked read port.
// Read responses queue in a 2-entry FIFO so consumers can stall without losing data.
module register_bank_reader #(
    parameter int W     = 64,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  D,
    input  logic          rd_req_valid,
    output logic          rd_req_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_rsp_valid,
    input  logic          rd_rsp_ready,
    output logic [W-1:0]  Q,
    output logic          rd_rsp_err
);

    // Handshake: a transfer happens at a rising edge where valid and ready are both high.
    logic [W-1:0] regs_q [DEPTH];
    logic [W-1:0] regs_d [DEPTH];
    logic [W-1:0] fifo_data_q [2];
    logic [W-1:0] fifo_data_d [2];
    logic         fifo_err_q [2];
    logic         fifo_err_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic [W-1:0] q_hold_q, q_hold_d;

    logic         push, pop;
    logic         rd_hit;
    logic [W-1:0] rd_val;

    assign rd_req_ready = (count_q < 2'd2);
    assign rd_rsp_valid = (count_q != 2'd0);
    assign push         = rd_req_valid & rd_req_ready;
    assign pop          = rd_rsp_valid & rd_rsp_ready;

    // Q keeps showing the last head once the FIFO drains.
    assign Q          = rd_rsp_valid ? fifo_data_q[rd_ptr_q] : q_hold_q;
    assign rd_rsp_err = rd_rsp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr && (wr_addr == AW'(i))) begin
                regs_d[i] = D;
            end
        end
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_hit = 1'b1;
                rd_val = regs_q[i];
            end
        end
        if (rd_hit && wr && (wr_addr == rd_addr)) begin
            rd_val = D;
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q;
        q_hold_d    = q_hold_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = rd_val;
            fifo_err_d[wr_ptr_q]  = ~rd_hit;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (rd_rsp_valid) begin
            q_hold_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            regs_q      <= '{default: '0};
            fifo_data_q <= '{default: '0};
            fifo_err_q  <= '{default: 1'b0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            q_hold_q    <= '0;
        end else begin
            regs_q      <= regs_d;
            fifo_data_q <= fifo_data_d;
            fifo_err_q  <= fifo_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            q_hold_q    <= q_hold_d;
        end
    end

endmodule
